// File: rtl/time_set_ctrl_pkg.sv
// Shared definitions for the time-setting front end: FSM states, field codes
// and the wrap limits of the editable time fields.
package time_set_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_SET_HR  = 3'd1,
    ST_SET_MIN = 3'd2,
    ST_SET_SEC = 3'd3,
    ST_COMMIT  = 3'd4
  } state_e;

  localparam logic [1:0] FIELD_NONE = 2'd0;
  localparam logic [1:0] FIELD_HR   = 2'd1;
  localparam logic [1:0] FIELD_MIN  = 2'd2;
  localparam logic [1:0] FIELD_SEC  = 2'd3;

  localparam logic [4:0] HOUR_MAX   = 5'd23;
  localparam logic [5:0] MINSEC_MAX = 6'd59;

  // Increment with wrap to zero once the field limit is reached.
  function automatic logic [5:0] wrap_inc(input logic [5:0] v, input logic [5:0] max);
    return (v >= max) ? 6'd0 : v + 6'd1;
  endfunction

endpackage

// File: rtl/time_set_ctrl_btn_debounce.sv
// Push-button conditioner: 2-flop synchronizer, stability counter, accepted
// level and a one-cycle press pulse on each accepted 1-to-0 change.
// press_o is a single-cycle strobe with no back-pressure: the consumer must
// act on it in the cycle it is high, otherwise the press is lost.
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_raw_i,
  output logic press_o
);

  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES + 1) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1_q, sync2_q;
  logic          level_q, level_d;
  logic          level_dly_q;
  logic          press_q;
  logic [CW-1:0] cnt_q, cnt_d;

  // Count cycles the synchronized level has disagreed with the accepted level.
  always_comb begin
    cnt_d   = '0;
    level_d = level_q;
    if (sync2_q != level_q) begin
      if (cnt_q == CNT_LAST) begin
        level_d = sync2_q;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  // Synchronizer, counter, accepted level and registered press pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q     <= 1'b1;
      sync2_q     <= 1'b1;
      level_q     <= 1'b1;
      level_dly_q <= 1'b1;
      cnt_q       <= '0;
      press_q     <= 1'b0;
    end else begin
      sync1_q     <= btn_raw_i;
      sync2_q     <= sync1_q;
      level_q     <= level_d;
      level_dly_q <= level_q;
      cnt_q       <= cnt_d;
      press_q     <= level_dly_q & ~level_q;
    end
  end

  assign press_o = press_q;

endmodule

// File: rtl/time_set_ctrl.sv
// Time-setting controller: captures the running time on switch rise, edits
// hour/minute/second field by field, and issues a one-cycle load on switch fall.
module time_set_ctrl
  import time_set_ctrl_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int BLINK_CYCLES    = 12500000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       slideSwitch,
  input  logic       btnNext,
  input  logic       btnInc,
  input  logic [4:0] curHour,
  input  logic [5:0] curMin,
  input  logic [5:0] curSec,
  output logic       setActive,
  output logic [1:0] selField,
  output logic [4:0] editHour,
  output logic [5:0] editMin,
  output logic [5:0] editSec,
  output logic       blinkOn,
  output logic       loadEn,
  output logic [4:0] loadHour,
  output logic [5:0] loadMin,
  output logic [5:0] loadSec,
  output logic [2:0] dbgState
);

  localparam int BW = (BLINK_CYCLES > 1) ? $clog2(BLINK_CYCLES + 1) : 1;
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_CYCLES - 1);

  state_e        state_q, state_d;
  logic [4:0]    edit_hr_q, edit_hr_d;
  logic [5:0]    edit_min_q, edit_min_d;
  logic [5:0]    edit_sec_q, edit_sec_d;
  logic [BW-1:0] blink_cnt_q, blink_cnt_d;
  logic          blink_q, blink_d;
  logic          pend_q, pend_d;
  logic          sw_s1_q, sw_s2_q, sw_prev_q;
  logic [1:0]    warm_q;
  logic          sw_rise, sw_fall;
  logic          inc_press, next_press;

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_inc (
    .clk      (clk),
    .rst      (rst),
    .btn_raw_i(btnInc),
    .press_o  (inc_press)
  );

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_next (
    .clk      (clk),
    .rst      (rst),
    .btn_raw_i(btnNext),
    .press_o  (next_press)
  );

  // Switch synchronizer and edge history. The synchronizer holds no real
  // sample for two edges after reset, so the edge history is pinned high until
  // then: a switch left on across reset must not look like a fresh rise.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sw_s1_q   <= 1'b0;
      sw_s2_q   <= 1'b0;
      sw_prev_q <= 1'b1;
      warm_q    <= 2'b00;
    end else begin
      sw_s1_q   <= slideSwitch;
      sw_s2_q   <= sw_s1_q;
      sw_prev_q <= warm_q[1] ? sw_s2_q : 1'b1;
      warm_q    <= {warm_q[0], 1'b1};
    end
  end

  assign sw_rise = sw_s2_q & ~sw_prev_q;
  assign sw_fall = ~sw_s2_q & sw_prev_q;

  // Next-state and edit-field logic; switch fall outranks any press.
  always_comb begin
    state_d    = state_q;
    edit_hr_d  = edit_hr_q;
    edit_min_d = edit_min_q;
    edit_sec_d = edit_sec_q;
    pend_d     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (sw_rise || pend_q) begin
          state_d    = ST_SET_HR;
          edit_hr_d  = curHour;
          edit_min_d = curMin;
          edit_sec_d = curSec;
        end
      end
      ST_SET_HR, ST_SET_MIN, ST_SET_SEC: begin
        if (sw_fall) begin
          state_d = ST_COMMIT;
        end else begin
          if (inc_press) begin
            case (state_q)
              ST_SET_HR:  edit_hr_d  = 5'(wrap_inc({1'b0, edit_hr_q}, {1'b0, HOUR_MAX}));
              ST_SET_MIN: edit_min_d = wrap_inc(edit_min_q, MINSEC_MAX);
              default:    edit_sec_d = wrap_inc(edit_sec_q, MINSEC_MAX);
            endcase
          end
          if (next_press) begin
            case (state_q)
              ST_SET_HR:  state_d = ST_SET_MIN;
              ST_SET_MIN: state_d = ST_SET_SEC;
              default:    state_d = ST_SET_HR;
            endcase
          end
        end
      end
      ST_COMMIT: begin
        state_d = ST_IDLE;
        pend_d  = sw_rise;  // rise during COMMIT is replayed from IDLE
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Blink timer: runs only while a field is being edited, restarts visible.
  always_comb begin
    blink_cnt_d = '0;
    blink_d     = 1'b1;
    if ((state_d inside {ST_SET_HR, ST_SET_MIN, ST_SET_SEC}) && (state_d == state_q)) begin
      if (blink_cnt_q == BLINK_LAST) begin
        blink_d = ~blink_q;
      end else begin
        blink_cnt_d = blink_cnt_q + BW'(1);
        blink_d     = blink_q;
      end
    end
  end

  // State, edit and blink registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      edit_hr_q   <= '0;
      edit_min_q  <= '0;
      edit_sec_q  <= '0;
      blink_cnt_q <= '0;
      blink_q     <= 1'b1;
      pend_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      edit_hr_q   <= edit_hr_d;
      edit_min_q  <= edit_min_d;
      edit_sec_q  <= edit_sec_d;
      blink_cnt_q <= blink_cnt_d;
      blink_q     <= blink_d;
      pend_q      <= pend_d;
    end
  end

  // Field selector decoded from the current state.
  always_comb begin
    selField = FIELD_NONE;
    case (state_q)
      ST_SET_HR:  selField = FIELD_HR;
      ST_SET_MIN: selField = FIELD_MIN;
      ST_SET_SEC: selField = FIELD_SEC;
      default:    selField = FIELD_NONE;
    endcase
  end

  assign setActive = state_q inside {ST_SET_HR, ST_SET_MIN, ST_SET_SEC};
  assign loadEn    = (state_q == ST_COMMIT);
  assign editHour  = edit_hr_q;
  assign editMin   = edit_min_q;
  assign editSec   = edit_sec_q;
  assign loadHour  = edit_hr_q;
  assign loadMin   = edit_min_q;
  assign loadSec   = edit_sec_q;
  assign blinkOn   = blink_q;
  assign dbgState  = state_q;

endmodule
